// File: rtl/alt_vipcti130_vid2is_sync_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : alt_vipcti130_vid2is_sync_lock_controller
// Purpose  : Sequences the embedded-sync extractor. It measures active width,
//            active lines per field and interlace from the decoded h/v/f/
//            datavalid stream. It asserts vid_locked once the format has
//            repeated for LOCK_FRAMES frames, and drops lock on a persistent
//            format change or on loss of vertical timing.
// Ports    : clk, rst (sync, active-low)      - clock / reset
//            enable                           - 0 forces IDLE
//            vid_enable                       - sample qualifier
//            vid_h_sync/v_sync/f/datavalid    - decoded extractor stream
//            vid_locked                       - lock to extractor / status
//            active_width, active_height_f0/f1, interlaced - locked format
//            resolution_changed               - pulse on lock loss
//            state_out                        - FSM state for status
// Revision : 1.0 - initial release
// ============================================================================
module alt_vipcti130_vid2is_sync_lock_controller #(
  parameter int CNT_WIDTH      = 16,
  parameter int LOCK_FRAMES    = 3,
  parameter int UNLOCK_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 4194304
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 vid_enable,
  input  logic                 vid_h_sync,
  input  logic                 vid_v_sync,
  input  logic                 vid_f,
  input  logic                 vid_datavalid,
  output logic                 vid_locked,
  output logic [CNT_WIDTH-1:0] active_width,
  output logic [CNT_WIDTH-1:0] active_height_f0,
  output logic [CNT_WIDTH-1:0] active_height_f1,
  output logic                 interlaced,
  output logic                 resolution_changed,
  output logic [2:0]           state_out
);

  localparam int MC_W = $clog2(LOCK_FRAMES + 1);
  localparam int MS_W = $clog2(UNLOCK_FRAMES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [MC_W-1:0]      C_LOCK_N  = MC_W'(LOCK_FRAMES);
  localparam logic [MS_W-1:0]      C_MISS_N  = MS_W'(UNLOCK_FRAMES);
  localparam logic [TO_W-1:0]      C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEARCH  = 3'd1,
    S_MEASURE = 3'd2,
    S_CONFIRM = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Measurement path registers
  // --------------------------------------------------------------------------
  logic                 dv_prev_q, dv_prev_d;
  logic                 v_prev_q, v_prev_d;
  logic                 last_f_q, last_f_d;     // f on latest active sample
  logic                 prev_f_q, prev_f_d;     // f of the previous field
  logic [CNT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0] lcnt_q, lcnt_d;
  logic [CNT_WIDTH-1:0] fwidth_q, fwidth_d;
  logic                 fwidth_vld_q, fwidth_vld_d;
  logic                 fbad_q, fbad_d;
  logic [CNT_WIDTH-1:0] pf_h_q, pf_h_d;         // previous field snapshot
  logic [CNT_WIDTH-1:0] pf_w_q, pf_w_d;
  logic                 pf_bad_q, pf_bad_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  // --------------------------------------------------------------------------
  // Control path registers
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic [MS_W-1:0]      miss_cnt_q, miss_cnt_d;
  logic [CNT_WIDTH-1:0] ref_w_q, ref_w_d;
  logic [CNT_WIDTH-1:0] ref_h0_q, ref_h0_d;
  logic [CNT_WIDTH-1:0] ref_h1_q, ref_h1_d;
  logic                 ref_il_q, ref_il_d;
  logic                 locked_q, locked_d;
  logic [CNT_WIDTH-1:0] act_w_q, act_w_d;
  logic [CNT_WIDTH-1:0] act_h0_q, act_h0_d;
  logic [CNT_WIDTH-1:0] act_h1_q, act_h1_d;
  logic                 act_il_q, act_il_d;
  logic                 rc_q, rc_d;

  // --------------------------------------------------------------------------
  // Event decode (only enabled cycles count)
  // --------------------------------------------------------------------------
  logic                 w_dv;
  logic                 w_dv_rise;
  logic                 w_dv_fall;
  logic                 w_field_end;
  logic                 w_cand;
  logic                 w_frame_end;
  logic                 w_to_hit;
  logic [CNT_WIDTH-1:0] w_fr_h0;
  logic [CNT_WIDTH-1:0] w_fr_h1;
  logic                 w_fr_bad;
  logic                 w_match;
  logic [MC_W-1:0]      w_match_inc;
  logic [MS_W-1:0]      w_miss_inc;

  assign w_dv        = vid_enable & vid_datavalid;
  assign w_dv_rise   = vid_enable & vid_datavalid & ~dv_prev_q;
  assign w_dv_fall   = vid_enable & ~vid_datavalid & dv_prev_q;
  assign w_field_end = vid_enable & vid_v_sync & ~v_prev_q;
  assign w_cand      = last_f_q ^ prev_f_q;
  // A progressive field is a whole frame; an interlaced frame ends on f=1.
  assign w_frame_end = w_field_end & (~w_cand | last_f_q);
  assign w_to_hit    = (to_cnt_q == C_TO_LAST);

  // For an interlaced frame the f0 half comes from the previous-field snapshot
  // and both halves must agree on line width.
  assign w_fr_h0  = w_cand ? pf_h_q : lcnt_q;
  assign w_fr_h1  = w_cand ? lcnt_q : '0;
  assign w_fr_bad = fbad_q | (w_cand & (pf_bad_q | (pf_w_q != fwidth_q)));
  assign w_match  = ~w_fr_bad
                  & (fwidth_q == ref_w_q)
                  & (w_fr_h0  == ref_h0_q)
                  & (w_fr_h1  == ref_h1_q)
                  & (w_cand   == ref_il_q);

  assign w_match_inc = match_cnt_q + MC_W'(1);
  assign w_miss_inc  = miss_cnt_q + MS_W'(1);

  // --------------------------------------------------------------------------
  // Measurement next-state
  // --------------------------------------------------------------------------
  always_comb begin
    dv_prev_d    = dv_prev_q;
    v_prev_d     = v_prev_q;
    last_f_d     = last_f_q;
    prev_f_d     = prev_f_q;
    wcnt_d       = wcnt_q;
    lcnt_d       = lcnt_q;
    fwidth_d     = fwidth_q;
    fwidth_vld_d = fwidth_vld_q;
    fbad_d       = fbad_q;
    pf_h_d       = pf_h_q;
    pf_w_d       = pf_w_q;
    pf_bad_d     = pf_bad_q;

    if (vid_enable) begin
      dv_prev_d = vid_datavalid;
      v_prev_d  = vid_v_sync;
      if (vid_datavalid) begin
        last_f_d = vid_f;
      end
    end

    if (w_dv) begin
      if (wcnt_q == C_CNT_MAX) begin
        fbad_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + CNT_WIDTH'(1);
      end
      // Active data inside horizontal blanking means the decode is corrupt.
      if (vid_h_sync) begin
        fbad_d = 1'b1;
      end
    end

    if (w_dv_fall) begin
      if (!fwidth_vld_q) begin
        fwidth_d     = wcnt_q;
        fwidth_vld_d = 1'b1;
      end else if (wcnt_q != fwidth_q) begin
        fbad_d = 1'b1;
      end
      wcnt_d = '0;
    end

    if (w_dv_rise) begin
      if (lcnt_q == C_CNT_MAX) begin
        fbad_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + CNT_WIDTH'(1);
      end
    end

    // Field end: snapshot this field for the next one, then start afresh.
    if (w_field_end) begin
      prev_f_d     = last_f_q;
      pf_h_d       = lcnt_q;
      pf_w_d       = fwidth_q;
      pf_bad_d     = fbad_q;
      lcnt_d       = '0;
      fwidth_d     = '0;
      fwidth_vld_d = 1'b0;
      fbad_d       = 1'b0;
    end

    to_cnt_d = (w_field_end | w_to_hit) ? '0 : to_cnt_q + TO_W'(1);
  end

  // --------------------------------------------------------------------------
  // Lock FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ref_w_d     = ref_w_q;
    ref_h0_d    = ref_h0_q;
    ref_h1_d    = ref_h1_q;
    ref_il_d    = ref_il_q;
    act_w_d     = act_w_q;
    act_h0_d    = act_h0_q;
    act_h1_d    = act_h1_q;
    act_il_d    = act_il_q;
    rc_d        = 1'b0;

    if (!enable) begin
      state_d     = S_IDLE;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_SEARCH;
    end else if (w_to_hit) begin
      // Timeout beats a coincident frame end.
      state_d     = S_SEARCH;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      rc_d        = (state_q == S_LOCKED);
    end else begin
      case (state_q)
        S_SEARCH: begin
          if (w_field_end) begin
            state_d = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (w_frame_end) begin
            ref_w_d     = fwidth_q;
            ref_h0_d    = w_fr_h0;
            ref_h1_d    = w_fr_h1;
            ref_il_d    = w_cand;
            match_cnt_d = '0;
            state_d     = S_CONFIRM;
          end
        end
        S_CONFIRM: begin
          if (w_frame_end) begin
            if (w_match) begin
              match_cnt_d = w_match_inc;
              if (w_match_inc == C_LOCK_N) begin
                state_d    = S_LOCKED;
                miss_cnt_d = '0;
                act_w_d    = ref_w_q;
                act_h0_d   = ref_h0_q;
                act_h1_d   = ref_h1_q;
                act_il_d   = ref_il_q;
              end
            end else begin
              ref_w_d     = fwidth_q;
              ref_h0_d    = w_fr_h0;
              ref_h1_d    = w_fr_h1;
              ref_il_d    = w_cand;
              match_cnt_d = '0;
            end
          end
        end
        S_LOCKED: begin
          if (w_frame_end) begin
            if (w_match) begin
              miss_cnt_d = '0;
            end else if (w_miss_inc == C_MISS_N) begin
              state_d     = S_SEARCH;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
              rc_d        = 1'b1;
            end else begin
              miss_cnt_d = w_miss_inc;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    locked_d = (state_d == S_LOCKED);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_prev_q    <= 1'b0;
      v_prev_q     <= 1'b0;
      last_f_q     <= 1'b0;
      prev_f_q     <= 1'b0;
      wcnt_q       <= '0;
      lcnt_q       <= '0;
      fwidth_q     <= '0;
      fwidth_vld_q <= 1'b0;
      fbad_q       <= 1'b0;
      pf_h_q       <= '0;
      pf_w_q       <= '0;
      pf_bad_q     <= 1'b0;
      to_cnt_q     <= '0;
      state_q      <= S_IDLE;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
      ref_w_q      <= '0;
      ref_h0_q     <= '0;
      ref_h1_q     <= '0;
      ref_il_q     <= 1'b0;
      locked_q     <= 1'b0;
      act_w_q      <= '0;
      act_h0_q     <= '0;
      act_h1_q     <= '0;
      act_il_q     <= 1'b0;
      rc_q         <= 1'b0;
    end else begin
      dv_prev_q    <= dv_prev_d;
      v_prev_q     <= v_prev_d;
      last_f_q     <= last_f_d;
      prev_f_q     <= prev_f_d;
      wcnt_q       <= wcnt_d;
      lcnt_q       <= lcnt_d;
      fwidth_q     <= fwidth_d;
      fwidth_vld_q <= fwidth_vld_d;
      fbad_q       <= fbad_d;
      pf_h_q       <= pf_h_d;
      pf_w_q       <= pf_w_d;
      pf_bad_q     <= pf_bad_d;
      to_cnt_q     <= to_cnt_d;
      state_q      <= state_d;
      match_cnt_q  <= match_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      ref_w_q      <= ref_w_d;
      ref_h0_q     <= ref_h0_d;
      ref_h1_q     <= ref_h1_d;
      ref_il_q     <= ref_il_d;
      locked_q     <= locked_d;
      act_w_q      <= act_w_d;
      act_h0_q     <= act_h0_d;
      act_h1_q     <= act_h1_d;
      act_il_q     <= act_il_d;
      rc_q         <= rc_d;
    end
  end

  assign vid_locked         = locked_q;
  assign active_width       = act_w_q;
  assign active_height_f0   = act_h0_q;
  assign active_height_f1   = act_h1_q;
  assign interlaced         = act_il_q;
  assign resolution_changed = rc_q;
  assign state_out          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_alt_vipcti130_vid2is_sync_lock_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alt_vipcti130_vid2is_sync_lock_controller
// Purpose  : Self-checking bench. Expected lock/unlock events are queued as
//            stimulus is scheduled and compared when the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alt_vipcti130_vid2is_sync_lock_controller;

  localparam int CW = 16;
  localparam int K_NONE = 0;
  localparam int K_LOCK = 1;
  localparam int K_UNLOCK = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          vid_enable;
  logic          vid_h_sync;
  logic          vid_v_sync;
  logic          vid_f;
  logic          vid_datavalid;
  logic          vid_locked;
  logic [CW-1:0] active_width;
  logic [CW-1:0] active_height_f0;
  logic [CW-1:0] active_height_f1;
  logic          interlaced;
  logic          resolution_changed;
  logic [2:0]    state_out;

  alt_vipcti130_vid2is_sync_lock_controller #(
    .CNT_WIDTH(CW), .LOCK_FRAMES(3), .UNLOCK_FRAMES(2), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .vid_enable(vid_enable),
    .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync), .vid_f(vid_f),
    .vid_datavalid(vid_datavalid), .vid_locked(vid_locked),
    .active_width(active_width), .active_height_f0(active_height_f0),
    .active_height_f1(active_height_f1), .interlaced(interlaced),
    .resolution_changed(resolution_changed), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int field;
    int w;
    int h0;
    int h1;
    int il;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   field_cnt = 0;
  bit   sd_mode = 0;
  bit   mon_prev = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_evt(input int kind, input int field, input int w,
                          input int h0, input int h1, input int il);
    evt_t e;
    e = '{kind, field, w, h0, h1, il};
    exp_q.push_back(e);
  endtask

  // One enabled sample; in SD mode each is followed by a disabled cycle
  // carrying random junk that the DUT must ignore.
  task automatic drive(input logic dv, input logic h, input logic v, input logic f, input bit fe);
    @(negedge clk);
    vid_enable    = 1'b1;
    vid_datavalid = dv;
    vid_h_sync    = h;
    vid_v_sync    = v;
    vid_f         = f;
    if (fe) field_cnt++;
    if (sd_mode) begin
      @(negedge clk);
      vid_enable    = 1'b0;
      vid_datavalid = 1'($urandom_range(0, 1));
      vid_h_sync    = 1'($urandom_range(0, 1));
      vid_v_sync    = 1'($urandom_range(0, 1));
      vid_f         = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_line(input int w, input logic f);
    for (int s = 0; s < w; s++) drive(1'b1, 1'b0, 1'b0, f, 1'b0);
    for (int s = 0; s < 4; s++) drive(1'b0, 1'b1, 1'b0, f, 1'b0);
  endtask

  // Active lines followed by two vertical-blank lines; the first blank
  // sample is the v rising edge (field end).
  task automatic send_field(input int w, input int lines, input logic f, input int bad_line);
    for (int l = 0; l < lines; l++) send_line((l == bad_line) ? 15 : w, f);
    for (int vl = 0; vl < 2; vl++)
      for (int s = 0; s < w + 4; s++)
        drive(1'b0, (s >= w), 1'b1, f, (vl == 0 && s == 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b0;
    vid_enable    = 1'b0;
    vid_datavalid = 1'b0;
    vid_h_sync    = 1'b0;
    vid_v_sync    = 1'b0;
    vid_f         = 1'b0;
    field_cnt     = 0;
    @(negedge clk);
    check_val("rst_locked", vid_locked, 0);
    check_val("rst_width", active_width, 0);
    check_val("rst_h0", active_height_f0, 0);
    check_val("rst_h1", active_height_f1, 0);
    check_val("rst_il", interlaced, 0);
    check_val("rst_rc", resolution_changed, 0);
    check_val("rst_state", state_out, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic on_event(input int kind);
    evt_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{K_NONE, -1, -1, -1, -1, -1};
    check_val("evt_kind", kind, e.kind);
    check_val("evt_field", field_cnt, e.field);
    check_val("evt_width", active_width, e.w);
    check_val("evt_h0", active_height_f0, e.h0);
    check_val("evt_h1", active_height_f1, e.h1);
    check_val("evt_il", interlaced, e.il);
    if (kind == K_LOCK) begin
      check_val("evt_lock_state", state_out, 4);
    end else begin
      check_val("evt_unlock_state", state_out, 1);
      check_val("evt_unlock_locked", vid_locked, 0);
    end
  endtask

  // Output monitor: a rising vid_locked or a resolution_changed pulse is an
  // event that must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (vid_locked === 1'b1 && !mon_prev) on_event(K_LOCK);
        if (resolution_changed === 1'b1) on_event(K_UNLOCK);
      end
      mon_prev = (vid_locked === 1'b1);
    end
  end

  initial begin
    rst = 1'b0; enable = 1'b0; vid_enable = 1'b0; vid_h_sync = 1'b0;
    vid_v_sync = 1'b0; vid_f = 1'b0; vid_datavalid = 1'b0;

    // Progressive 16x4: align + reference + 3 matches -> lock on field 5.
    do_reset();
    enable = 1'b1;
    push_evt(K_LOCK, 5, 16, 4, 0, 0);
    for (int i = 0; i < 7; i++) send_field(16, 4, 1'b0, -1);
    check_val("prog_width", active_width, 16);
    check_val("prog_h1", active_height_f1, 0);
    check_val("prog_pending", exp_q.size(), 0);

    // Single odd frame while locked is tolerated.
    send_field(12, 4, 1'b0, -1);
    send_field(16, 4, 1'b0, -1);
    send_field(16, 4, 1'b0, -1);
    check_val("glitch_locked", vid_locked, 1);

    // Two odd frames unlock (field 12), then relock at width 12 (field 17).
    push_evt(K_UNLOCK, 12, 16, 4, 0, 0);
    send_field(12, 4, 1'b0, -1);
    send_field(12, 4, 1'b0, -1);
    check_val("chg_unlocked", vid_locked, 0);
    push_evt(K_LOCK, 17, 12, 4, 0, 0);
    for (int i = 0; i < 6; i++) send_field(12, 4, 1'b0, -1);
    check_val("relock_width", active_width, 12);
    check_val("relock_pending", exp_q.size(), 0);

    // Vertical timing disappears -> timeout unlock with a pulse.
    push_evt(K_UNLOCK, 18, 12, 4, 0, 0);
    for (int i = 0; i < 80; i++) send_line(12, 1'b0);
    check_val("to_pending", exp_q.size(), 0);
    check_val("to_state", state_out, 1);
    check_val("to_locked", vid_locked, 0);

    // Interlaced 4/3 lines: frame ends on f=1 fields, lock on field 8.
    do_reset();
    push_evt(K_LOCK, 8, 16, 4, 3, 1);
    for (int i = 0; i < 9; i++) send_field(16, (i % 2) ? 3 : 4, 1'(i % 2), -1);
    check_val("il_flag", interlaced, 1);
    check_val("il_h1", active_height_f1, 3);
    check_val("il_pending", exp_q.size(), 0);

    // A 15-sample line in the 4th field restarts confirmation: lock at 7.
    do_reset();
    push_evt(K_LOCK, 7, 16, 4, 0, 0);
    for (int i = 0; i < 6; i++) send_field(16, 4, 1'b0, (i == 3) ? 1 : -1);
    check_val("bad_not_yet", vid_locked, 0);
    send_field(16, 4, 1'b0, -1);
    check_val("bad_pending", exp_q.size(), 0);

    // SD-rate qualifier toggling gives identical results; then reset mid-lock.
    do_reset();
    sd_mode = 1'b1;
    push_evt(K_LOCK, 5, 16, 4, 0, 0);
    for (int i = 0; i < 6; i++) send_field(16, 4, 1'b0, -1);
    check_val("sd_width", active_width, 16);
    check_val("sd_pending", exp_q.size(), 0);
    sd_mode = 1'b0;
    do_reset();

    // enable=0 during CONFIRM: IDLE, no pulse, no lock.
    for (int i = 0; i < 3; i++) send_field(16, 4, 1'b0, -1);
    check_val("dis_confirm", state_out, 3);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check_val("dis_state", state_out, 0);
    check_val("dis_locked", vid_locked, 0);
    for (int i = 0; i < 4; i++) send_field(16, 4, 1'b0, -1);
    check_val("dis_state_hold", state_out, 0);
    check_val("dis_width", active_width, 0);
    check_val("final_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alt_vipcti130_vid2is_sync_lock_controller.md
Name: alt_vipcti130_Vid2IS_sync_lock_controller

Overview:
- Sequences the embedded-sync extractor: watches its decoded h/v/f/datavalid stream and measures active width, active lines per field and interlace.
- Drives the extractor's vid_locked input once the measured format has been stable for LOCK_FRAMES frames.
- Drops lock on persistent format change or loss of vertical timing.
- Sits between the extractor and the downstream resolution/control registers of the clocked-video input.

Parameters:
CNT_WIDTH, 16, width of sample/line counters and measurement outputs
LOCK_FRAMES, 3, consecutive matching frames (after reference frame) required to lock
UNLOCK_FRAMES, 2, consecutive mismatching frames while locked before unlock
TIMEOUT_CYCLES, 4194304, clk cycles without a v rising edge before forced unlock/re-search

Ports:
clk  in  1  system/video clock
rst  in  1  synchronous reset, active-low
enable  in  1  controller enable; 0 forces IDLE
vid_enable  in  1  sample qualifier (same as extractor vid_enable)
vid_h_sync  in  1  decoded H (blanking) from extractor
vid_v_sync  in  1  decoded V from extractor
vid_f  in  1  decoded field bit
vid_datavalid  in  1  active-picture sample
vid_locked  out  1  lock to extractor and status
active_width  out  CNT_WIDTH  samples per active line
active_height_f0  out  CNT_WIDTH  active lines, field 0
active_height_f1  out  CNT_WIDTH  active lines, field 1 (0 if progressive)
interlaced  out  1  1 = f toggles field to field
resolution_changed  out  1  one-cycle pulse on lock loss due to mismatch or timeout
state_out  out  3  FSM state for status

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0, FSM IDLE, all counters and match/mismatch counts 0. Reset has priority over enable.
- All video inputs are evaluated only on cycles with vid_enable=1. Edge detection uses registered copies that update only on enabled cycles.
- Width counter:
  - Increments on each enabled cycle with datavalid=1.
  - On an enabled datavalid 1->0 transition, the line width is captured. The first line of a field sets field_width; any later line whose width differs from it sets field_bad.
  - The width counter clears after each capture.
- Line counter: increments on each enabled datavalid 0->1 transition (first sample of a line).
- Field end is an enabled v_sync 0->1 transition.
  - The ending field's f is the value sampled on the field's last active sample.
  - Counter saturation at 2^CNT_WIDTH-1 sets field_bad.
  - Line counter, field_width and field_bad clear after field end is processed.
- Frame end is a field end where interlaced_cand=0 or ending f=1. interlaced_cand=1 when ending f differs from the previous field's f.
- A frame matches when all of the following hold:
  - neither field is bad;
  - width is equal to the stored value;
  - heights are equal to the stored values;
  - the interlace candidate is equal to the stored value.
- FSM:
  - IDLE (0): outputs held. enable=1 -> SEARCH.
  - SEARCH (1): wait for the first field end (alignment, nothing stored) -> MEASURE.
  - MEASURE (2): at frame end, store width/heights/interlace as the reference. match_cnt=0 -> CONFIRM.
  - CONFIRM (3): at frame end, match -> match_cnt+1, and when it reaches LOCK_FRAMES -> LOCKED. Mismatch -> store new reference, match_cnt=0, stay.
  - LOCKED (4): vid_locked=1. Outputs updated from the reference on entry, one cycle after the frame end.
    - Mismatching frame: miss_cnt+1. Matching frame: miss_cnt=0.
    - When miss_cnt reaches UNLOCK_FRAMES -> SEARCH, vid_locked=0, resolution_changed pulse.
- Timeout: a free-running counter clears on every field end.
  - Reaching TIMEOUT_CYCLES in any state except IDLE -> SEARCH.
  - The resolution_changed pulse is issued only if leaving LOCKED.
- enable=0 in any state -> IDLE next cycle: vid_locked=0, no pulse, measurement outputs retain their last values.
- Simultaneous timeout and frame end in the same cycle: the timeout wins.
- Latency: vid_locked rises on the clk edge after the enabled cycle containing the qualifying v rise.

Test Plan:
- Progressive 16 active samples × 4 active lines, 4 h-blank samples, 2 v-blank lines, vid_enable=1 continuously -> vid_locked rises after 5th field end (1 align + 1 ref + 3 match); active_width=16, height_f0=4, height_f1=0, interlaced=0.
- Interlaced: same line format, fields with f alternating 0/1, heights 4/3 -> interlaced=1, height_f0=4, height_f1=3, lock after frame ends per FSM.
- While locked, change width to 12 for 1 frame then back -> stays locked. Width 12 for 2 frames -> vid_locked=0 and one resolution_changed pulse. Then relock with active_width=12.
- While locked, stop v edges -> after TIMEOUT_CYCLES (use small override, e.g. 1000) vid_locked=0, pulse, state_out=1.
- One line of 15 samples inside a field during CONFIRM -> field_bad, match_cnt resets, lock delayed by the full LOCK_FRAMES.
- vid_enable toggling 1/0 (SD 2x clock) -> identical measurements. rst=0 mid-LOCKED -> all outputs 0 on next clk. enable=0 mid-CONFIRM -> IDLE, no pulse.
